// File: rtl/seq_comp_n.sv
// seq_comp_n: digit-serial magnitude comparator (unsigned or two's complement), MSB digit first.
// Latency: done rises N edges after the accepting edge, N = index of first differing digit (WIDTH/DIGIT if equal).
// Backpressure: none; start is ignored while busy, clear aborts to IDLE at the next edge without a done pulse.
//
// Ports:
//   clock        rising-edge clock for all state
//   reset_n      asynchronous active-low reset
//   start        request a compare of in1 vs in2 (only looked at in IDLE)
//   clear        synchronous abort, overrides every other input
//   signed_mode  1 = two's-complement order, 0 = unsigned (captured with start)
//   in1, in2     operands (captured with start)
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle pulse when a new result is published
//   eq_out, gt_out, lt_out  registered result of in1 relative to in2
//
// WIDTH must be a positive multiple of DIGIT; DIGIT is 1, 2 or 4.

module seq_comp_n #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             eq_out,
  output logic             gt_out,
  output logic             lt_out
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;

  // Operands as they will be loaded. Flipping the sign bit of both maps
  // two's-complement order onto unsigned order, so the serial datapath only
  // ever does an unsigned compare and signed_mode need not be kept after accept.
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;

  always_comb begin
    a_load = in1;
    b_load = in2;
    a_load[WIDTH-1] = in1[WIDTH-1] ^ signed_mode;
    b_load[WIDTH-1] = in2[WIDTH-1] ^ signed_mode;
  end

  // Current most significant digit of each shift register.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_ne;
  logic             dig_gt;
  logic             last_dig;

  assign a_dig    = a_sr[WIDTH-1 -: DIGIT];
  assign b_dig    = b_sr[WIDTH-1 -: DIGIT];
  assign dig_ne   = (a_dig != b_dig);
  assign dig_gt   = (a_dig > b_dig);
  assign last_dig = (cnt == CW'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      eq_out <= 1'b1;
      gt_out <= 1'b0;
      lt_out <= 1'b0;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
    end else if (clear) begin
      // Abort from any state; the last published result stays visible.
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a_load;
            b_sr  <= b_load;
            cnt   <= CW'(NDIG);
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end

        ST_RUN: begin
          if (dig_ne) begin
            // First differing digit decides; remaining digits are irrelevant.
            gt_out <= dig_gt;
            lt_out <= ~dig_gt;
            eq_out <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (last_dig) begin
            gt_out <= 1'b0;
            lt_out <= 1'b0;
            eq_out <= 1'b1;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            a_sr <= a_sr << DIGIT;
            b_sr <= b_sr << DIGIT;
            cnt  <= cnt - CW'(1);
          end
        end

        ST_DONE: begin
          // A start seen here is deliberately dropped: only IDLE accepts.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
